// File: rtl/timer_pkg.sv
// Shared encodings for the timer family: clock-select values, prescaler divisors,
// and TCCR / TIFR bit positions.
package timer_pkg;

   typedef enum logic [2:0] {
      CS_STOP    = 3'd0,
      CS_DIV1    = 3'd1,
      CS_DIV8    = 3'd2,
      CS_DIV64   = 3'd3,
      CS_DIV256  = 3'd4,
      CS_DIV1024 = 3'd5,
      CS_STOP_6  = 3'd6,
      CS_STOP_7  = 3'd7
   } cs_e;

   localparam int unsigned PRESC_W  = 10;
   localparam int unsigned DIV_1    = 1;
   localparam int unsigned DIV_8    = 8;
   localparam int unsigned DIV_64   = 64;
   localparam int unsigned DIV_256  = 256;
   localparam int unsigned DIV_1024 = 1024;

   localparam int unsigned TCCR_CS_LSB = 0;
   localparam int unsigned TCCR_CS_W   = 3;
   localparam int unsigned TCCR_CTC    = 3;
   localparam int unsigned TCCR_OCRBUF = 4;
   localparam int unsigned TCCR_USED_W = 5;

   localparam int unsigned TIFR_TOV      = 0;
   localparam int unsigned TIFR_OCF_BASE = 1;

endpackage

// File: rtl/timer_prescaler.sv
// Free-running 10-bit prescaler; emits a one-cycle tick each time the low bits
// selected by CS are all ones.
module timer_prescaler
   import timer_pkg::*;
(
   input  logic clk,
   input  logic rst,
   input  cs_e  cs,
   input  logic clear,
   output logic tick
);

   logic [PRESC_W-1:0] cnt;
   logic [PRESC_W-1:0] mask;
   logic               run;

   always_ff @(posedge clk) begin
      if (rst || clear)
         cnt <= '0;
      else
         cnt <= cnt + PRESC_W'(1);
   end

   // All divisors divide 2^PRESC_W, so a masked compare on the wrapping counter is periodic.
   always_comb begin
      run  = 1'b1;
      mask = '0;
      case (cs)
         CS_DIV1:    mask = PRESC_W'(DIV_1 - 1);
         CS_DIV8:    mask = PRESC_W'(DIV_8 - 1);
         CS_DIV64:   mask = PRESC_W'(DIV_64 - 1);
         CS_DIV256:  mask = PRESC_W'(DIV_256 - 1);
         CS_DIV1024: mask = PRESC_W'(DIV_1024 - 1);
         default:    run  = 1'b0;
      endcase
   end

   assign tick = run && ((cnt & mask) == mask);

endmodule

// File: rtl/timer_nbit_multi_cmp.sv
// WIDTH-bit timer with NUM_CMP compare channels, normal/CTC modes, optional
// double-buffered compare registers and a masked, combined interrupt request.
module timer_nbit_multi_cmp
   import timer_pkg::*;
#(
   parameter  int unsigned WIDTH   = 16,
   parameter  int unsigned NUM_CMP = 2,
   localparam int unsigned SEL_W   = (NUM_CMP > 1) ? $clog2(NUM_CMP) : 1,
   localparam int unsigned NF      = NUM_CMP + 1
)
(
   input  logic                     sysClock,
   input  logic                     system_reset,
   input  logic [WIDTH-1:0]         TCNT_input,
   input  logic                     TCNT_write_enable,
   input  logic [WIDTH-1:0]         OCR_input,
   input  logic [SEL_W-1:0]         OCR_sel,
   input  logic                     OCR_write_enable,
   input  logic [7:0]               TCCR_input,
   input  logic                     TCCR_write_enable,
   input  logic [NF-1:0]            TIMSK_input,
   input  logic                     TIMSK_write_enable,
   input  logic [NF-1:0]            TIFR_input,
   input  logic                     TIFR_write_enable,
   output logic [WIDTH-1:0]         TCNT_output,
   output logic [7:0]               TCCR_output,
   output logic [NUM_CMP*WIDTH-1:0] OCR_output,
   output logic [NF-1:0]            TIMSK_output,
   output logic [NF-1:0]            TIFR_output,
   output logic                     irq
);

   logic [TCCR_USED_W-1:0] tccr;
   logic [WIDTH-1:0]       tcnt;
   logic [WIDTH-1:0]       ocr_act [NUM_CMP];
   logic [WIDTH-1:0]       ocr_buf [NUM_CMP];
   logic [NF-1:0]          tifr;
   logic [NF-1:0]          timsk;
   logic                   block;

   logic          tick;
   logic          step;
   logic          ctc;
   logic          buffered;
   logic          at_top;
   logic          ctc_hit;
   logic          wrap;
   logic          buf_clear;
   logic          copy;
   logic          direct_wr;
   logic [NF-1:0] hw_set;
   logic [NF-1:0] clr_mask;

   timer_prescaler u_presc (
      .clk   (sysClock),
      .rst   (system_reset),
      .cs    (cs_e'(tccr[TCCR_CS_LSB +: TCCR_CS_W])),
      .clear (TCCR_write_enable),
      .tick  (tick)
   );

   always_comb begin
      ctc       = tccr[TCCR_CTC];
      buffered  = tccr[TCCR_OCRBUF];
      step      = tick && !TCNT_write_enable;
      at_top    = (tcnt == '1);
      ctc_hit   = ctc && (tcnt == ocr_act[0]);
      wrap      = step && (ctc_hit || at_top);
      buf_clear = TCCR_write_enable && !TCCR_input[TCCR_OCRBUF];
      copy      = buf_clear || (buffered && wrap);
      direct_wr = !buffered || buf_clear;
      clr_mask  = TIFR_write_enable ? TIFR_input : '0;
      hw_set    = '0;
      hw_set[TIFR_TOV] = step && at_top;
      // A TCNT write suppresses compare matches on the following tick only.
      for (int unsigned i = 0; i < NUM_CMP; i++)
         hw_set[TIFR_OCF_BASE + i] = step && !block && (tcnt == ocr_act[i]);
   end

   always_ff @(posedge sysClock) begin
      if (system_reset) begin
         tccr  <= '0;
         tcnt  <= '0;
         tifr  <= '0;
         timsk <= '0;
         block <= 1'b0;
         for (int unsigned i = 0; i < NUM_CMP; i++) begin
            ocr_act[i] <= '0;
            ocr_buf[i] <= '0;
         end
      end else begin
         if (TCCR_write_enable)
            tccr <= TCCR_input[TCCR_USED_W-1:0];
         if (TIMSK_write_enable)
            timsk <= TIMSK_input;
         tifr <= (tifr & ~clr_mask) | hw_set;

         if (TCNT_write_enable) begin
            tcnt  <= TCNT_input;
            block <= 1'b1;
         end else if (step) begin
            block <= 1'b0;
            tcnt  <= (ctc_hit || at_top) ? '0 : tcnt + WIDTH'(1);
         end

         // Copy-from-buffer first; a same-cycle CPU write to the channel then overrides it.
         for (int unsigned i = 0; i < NUM_CMP; i++) begin
            if (copy)
               ocr_act[i] <= ocr_buf[i];
            if (OCR_write_enable && (OCR_sel == SEL_W'(i))) begin
               ocr_buf[i] <= OCR_input;
               if (direct_wr)
                  ocr_act[i] <= OCR_input;
            end
         end
      end
   end

   always_comb begin
      OCR_output = '0;
      for (int unsigned i = 0; i < NUM_CMP; i++)
         OCR_output[i*WIDTH +: WIDTH] = ocr_buf[i];
   end

   assign TCNT_output  = tcnt;
   assign TCCR_output  = {{(8 - TCCR_USED_W){1'b0}}, tccr};
   assign TIMSK_output = timsk;
   assign TIFR_output  = tifr;
   assign irq          = |(tifr & timsk);

endmodule

// File: tb/tb_timer_nbit_multi_cmp.sv
// Scoreboard bench: driver applies stimulus and pushes model predictions; monitor compares after each edge.
module tb_timer_nbit_multi_cmp;

   localparam int unsigned WIDTH   = 16;
   localparam int unsigned NUM_CMP = 2;
   localparam int unsigned SEL_W   = 1;
   localparam int unsigned NF      = NUM_CMP + 1;
   localparam int unsigned MAXV    = (1 << WIDTH) - 1;

   logic                     clk = 1'b0;
   logic                     rst;
   logic [WIDTH-1:0]         tcnt_in;
   logic                     tcnt_we;
   logic [WIDTH-1:0]         ocr_in;
   logic [SEL_W-1:0]         ocr_sel;
   logic                     ocr_we;
   logic [7:0]               tccr_in;
   logic                     tccr_we;
   logic [NF-1:0]            timsk_in;
   logic                     timsk_we;
   logic [NF-1:0]            tifr_in;
   logic                     tifr_we;
   logic [WIDTH-1:0]         tcnt_out;
   logic [7:0]               tccr_out;
   logic [NUM_CMP*WIDTH-1:0] ocr_out;
   logic [NF-1:0]            timsk_out;
   logic [NF-1:0]            tifr_out;
   logic                     irq;

   always #5 clk = ~clk;

   timer_nbit_multi_cmp #(.WIDTH(WIDTH), .NUM_CMP(NUM_CMP)) dut (
      .sysClock           (clk),
      .system_reset       (rst),
      .TCNT_input         (tcnt_in),
      .TCNT_write_enable  (tcnt_we),
      .OCR_input          (ocr_in),
      .OCR_sel            (ocr_sel),
      .OCR_write_enable   (ocr_we),
      .TCCR_input         (tccr_in),
      .TCCR_write_enable  (tccr_we),
      .TIMSK_input        (timsk_in),
      .TIMSK_write_enable (timsk_we),
      .TIFR_input         (tifr_in),
      .TIFR_write_enable  (tifr_we),
      .TCNT_output        (tcnt_out),
      .TCCR_output        (tccr_out),
      .OCR_output         (ocr_out),
      .TIMSK_output       (timsk_out),
      .TIFR_output        (tifr_out),
      .irq                (irq)
   );

   typedef struct {
      bit              rst;
      bit              tcnt_we;
      bit [WIDTH-1:0]  tcnt_in;
      bit              ocr_we;
      bit [SEL_W-1:0]  sel;
      bit [WIDTH-1:0]  ocr_in;
      bit              tccr_we;
      bit [7:0]        tccr_in;
      bit              timsk_we;
      bit [NF-1:0]     timsk_in;
      bit              tifr_we;
      bit [NF-1:0]     tifr_in;
   } stim_t;

   typedef struct {
      bit [WIDTH-1:0]         tcnt;
      bit [7:0]               tccr;
      bit [NUM_CMP*WIDTH-1:0] ocr;
      bit [NF-1:0]            timsk;
      bit [NF-1:0]            tifr;
      bit                     irq;
   } exp_t;

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   // Reference state, in plain integers
   int unsigned m_tcnt;
   int unsigned m_act[NUM_CMP];
   int unsigned m_buf[NUM_CMP];
   bit [7:0]    m_tccr;
   bit [NF-1:0] m_timsk;
   bit [NF-1:0] m_tifr;
   bit          m_block;
   int unsigned m_pcount;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int unsigned divisor_of(input bit [2:0] cs);
      case (cs)
         3'd1:    return 1;
         3'd2:    return 8;
         3'd3:    return 64;
         3'd4:    return 256;
         3'd5:    return 1024;
         default: return 0;
      endcase
   endfunction

   task automatic model_reset();
      m_tcnt = 0; m_tccr = 0; m_timsk = 0; m_tifr = 0; m_block = 0; m_pcount = 0;
      for (int i = 0; i < NUM_CMP; i++) begin
         m_act[i] = 0;
         m_buf[i] = 0;
      end
   endtask

   task automatic model_step(input stim_t s);
      int unsigned div;
      int unsigned nxt;
      int unsigned old_buf[NUM_CMP];
      bit          counting;
      bit          wrapped;
      bit [NF-1:0] set;
      if (s.rst) begin
         model_reset();
         return;
      end
      div      = divisor_of(m_tccr[2:0]);
      counting = (div != 0) && ((m_pcount % div) == div - 1) && !s.tcnt_we;
      set      = '0;
      wrapped  = 0;
      nxt      = m_tcnt;
      if (counting) begin
         if (!m_block)
            for (int i = 0; i < NUM_CMP; i++)
               if (m_tcnt == m_act[i]) set[1 + i] = 1'b1;
         if (m_tcnt == MAXV) set[0] = 1'b1;
         if ((m_tccr[3] && m_tcnt == m_act[0]) || m_tcnt == MAXV) begin
            nxt = 0;
            wrapped = 1;
         end else begin
            nxt = m_tcnt + 1;
         end
      end
      for (int i = 0; i < NUM_CMP; i++) old_buf[i] = m_buf[i];
      if (s.ocr_we) m_buf[s.sel] = s.ocr_in;
      if (s.tccr_we && !s.tccr_in[4]) begin
         for (int i = 0; i < NUM_CMP; i++) m_act[i] = m_buf[i];
      end else if (m_tccr[4]) begin
         if (wrapped) for (int i = 0; i < NUM_CMP; i++) m_act[i] = old_buf[i];
      end else if (s.ocr_we) begin
         m_act[s.sel] = s.ocr_in;
      end
      m_tifr = (m_tifr & ~(s.tifr_we ? s.tifr_in : '0)) | set;
      if (s.tcnt_we) begin
         m_tcnt  = s.tcnt_in;
         m_block = 1;
      end else begin
         m_tcnt = nxt;
         if (counting) m_block = 0;
      end
      if (s.timsk_we) m_timsk = s.timsk_in;
      if (s.tccr_we) m_tccr = {3'b000, s.tccr_in[4:0]};
      m_pcount = s.tccr_we ? 0 : m_pcount + 1;
   endtask

   function automatic exp_t snapshot();
      exp_t e;
      e.tcnt  = WIDTH'(m_tcnt);
      e.tccr  = m_tccr;
      e.timsk = m_timsk;
      e.tifr  = m_tifr;
      e.irq   = |(m_tifr & m_timsk);
      e.ocr   = '0;
      for (int i = 0; i < NUM_CMP; i++) e.ocr[i*WIDTH +: WIDTH] = WIDTH'(m_buf[i]);
      return e;
   endfunction

   function automatic stim_t idle();
      stim_t s;
      s = '{default: '0};
      return s;
   endfunction

   task automatic step(input stim_t s);
      @(negedge clk);
      rst      = s.rst;
      tcnt_we  = s.tcnt_we;  tcnt_in  = s.tcnt_in;
      ocr_we   = s.ocr_we;   ocr_sel  = s.sel;     ocr_in = s.ocr_in;
      tccr_we  = s.tccr_we;  tccr_in  = s.tccr_in;
      timsk_we = s.timsk_we; timsk_in = s.timsk_in;
      tifr_we  = s.tifr_we;  tifr_in  = s.tifr_in;
      model_step(s);
      exp_q.push_back(snapshot());
   endtask

   task automatic after_edge();
      @(posedge clk);
      #2;
   endtask

   task automatic do_reset();
      stim_t s;
      s = idle();
      s.rst = 1;
      step(s);
   endtask

   function automatic stim_t rand_stim();
      stim_t s;
      bit [2:0] cs_tab[7];
      cs_tab = '{3'd1, 3'd1, 3'd1, 3'd2, 3'd0, 3'd3, 3'd6};
      s = idle();
      s.rst      = ($urandom_range(0, 299) == 0);
      s.tcnt_we  = ($urandom_range(0, 19) == 0);
      case ($urandom_range(0, 3))
         0:       s.tcnt_in = WIDTH'($urandom);
         1:       s.tcnt_in = WIDTH'(16'hFFF0 + $urandom_range(0, 15));
         2:       s.tcnt_in = WIDTH'(m_act[$urandom_range(0, NUM_CMP - 1)]);
         default: s.tcnt_in = WIDTH'($urandom_range(0, 31));
      endcase
      s.ocr_we   = ($urandom_range(0, 14) == 0);
      s.sel      = SEL_W'($urandom_range(0, NUM_CMP - 1));
      s.ocr_in   = ($urandom_range(0, 9) == 0) ? WIDTH'(MAXV) : WIDTH'($urandom_range(0, 40));
      s.tccr_we  = ($urandom_range(0, 39) == 0);
      s.tccr_in  = 8'($urandom);
      s.tccr_in[2:0] = cs_tab[$urandom_range(0, 6)];
      s.timsk_we = ($urandom_range(0, 9) == 0);
      s.timsk_in = NF'($urandom);
      s.tifr_we  = ($urandom_range(0, 7) == 0);
      s.tifr_in  = NF'($urandom);
      return s;
   endfunction

   // Monitor: every edge after the first stimulus produces one prediction to compare
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("sb_tcnt",  32'(tcnt_out),  32'(e.tcnt));
            check("sb_tccr",  32'(tccr_out),  32'(e.tccr));
            check("sb_ocr",   32'(ocr_out),   32'(e.ocr));
            check("sb_timsk", 32'(timsk_out), 32'(e.timsk));
            check("sb_tifr",  32'(tifr_out),  32'(e.tifr));
            check("sb_irq",   32'(irq),       32'(e.irq));
         end
      end
   end

   initial begin
      stim_t s;
      rst = 1; tcnt_we = 0; tcnt_in = '0; ocr_we = 0; ocr_sel = '0; ocr_in = '0;
      tccr_we = 0; tccr_in = '0; timsk_we = 0; timsk_in = '0; tifr_we = 0; tifr_in = '0;
      model_reset();

      do_reset(); do_reset();
      after_edge();
      check("reset_tcnt", 32'(tcnt_out), 0);
      check("reset_irq",  32'(irq), 0);

      // Normal-mode wrap with /1
      s = idle(); s.tccr_we = 1; s.tccr_in = 8'h01; s.tcnt_we = 1; s.tcnt_in = 16'hFFFE;
      step(s); after_edge();
      check("t1_preload", 32'(tcnt_out), 32'hFFFE);
      step(idle()); after_edge();
      check("t1_top", 32'(tcnt_out), 32'hFFFF);
      check("t1_no_tov_yet", 32'(tifr_out[0]), 0);
      step(idle()); after_edge();
      check("t1_wrap", 32'(tcnt_out), 0);
      check("t1_tov", 32'(tifr_out[0]), 1);
      check("t1_irq_masked", 32'(irq), 0);
      s = idle(); s.timsk_we = 1; s.timsk_in = 3'b001;
      step(s); after_edge();
      check("t1_irq_unmasked", 32'(irq), 1);

      // CTC /8, TOP=4
      do_reset();
      s = idle(); s.ocr_we = 1; s.sel = 0; s.ocr_in = 16'd4; step(s);
      s = idle(); s.tccr_we = 1; s.tccr_in = 8'h0A; step(s);
      repeat (48) step(idle());
      after_edge();
      check("t2_tcnt", 32'(tcnt_out), 1);
      check("t2_ocf0", 32'(tifr_out[1]), 1);
      check("t2_no_tov", 32'(tifr_out[0]), 0);

      // CTC with buffered OCR0: 5 -> 2 written at TCNT=1
      do_reset();
      s = idle(); s.ocr_we = 1; s.sel = 0; s.ocr_in = 16'd5; step(s);
      s = idle(); s.tccr_we = 1; s.tccr_in = 8'h19; step(s);
      step(idle());
      s = idle(); s.ocr_we = 1; s.sel = 0; s.ocr_in = 16'd2; step(s); after_edge();
      check("t3_tcnt_at_write", 32'(tcnt_out), 2);
      check("t3_ocr_view", 32'(ocr_out[WIDTH-1:0]), 2);
      repeat (3) step(idle());
      after_edge();
      check("t3_old_top", 32'(tcnt_out), 5);
      step(idle()); after_edge();
      check("t3_wrap_long", 32'(tcnt_out), 0);
      repeat (3) step(idle());
      after_edge();
      check("t3_wrap_short", 32'(tcnt_out), 0);

      // Compare blocking after a TCNT write
      do_reset();
      s = idle(); s.ocr_we = 1; s.sel = 1; s.ocr_in = 16'h10; step(s);
      s = idle(); s.tccr_we = 1; s.tccr_in = 8'h01; s.tcnt_we = 1; s.tcnt_in = 16'h10; step(s);
      step(idle()); after_edge();
      check("t4_tcnt", 32'(tcnt_out), 32'h11);
      check("t4_blocked", 32'(tifr_out[2]), 0);
      s = idle(); s.tcnt_we = 1; s.tcnt_in = 16'h0F; step(s);
      step(idle()); step(idle()); after_edge();
      check("t4_ocf1", 32'(tifr_out[2]), 1);

      // Hardware set beats W1C; writing zeros clears nothing
      s = idle(); s.tifr_we = 1; s.tifr_in = 3'b111; s.tcnt_we = 1; s.tcnt_in = 16'h0F; step(s);
      step(idle());
      s = idle(); s.tifr_we = 1; s.tifr_in = 3'b100; step(s); after_edge();
      check("t5_set_wins", 32'(tifr_out[2]), 1);
      s = idle(); s.tifr_we = 1; s.tifr_in = 3'b000; step(s); after_edge();
      check("t5_zero_write", 32'(tifr_out), 32'b100);

      // Reset mid-count
      s = idle(); s.tccr_we = 1; s.tccr_in = 8'h01; s.tcnt_we = 1; s.tcnt_in = 16'h1234; s.timsk_we = 1; s.timsk_in = 3'b111;
      step(s);
      repeat (3) step(idle());
      do_reset(); after_edge();
      check("t6_tcnt", 32'(tcnt_out), 0);
      check("t6_tccr", 32'(tccr_out), 0);
      check("t6_tifr", 32'(tifr_out), 0);
      check("t6_timsk", 32'(timsk_out), 0);
      check("t6_irq", 32'(irq), 0);
      repeat (5) step(idle());
      after_edge();
      check("t6_stopped", 32'(tcnt_out), 0);

      repeat (4000) step(rand_stim());

      repeat (3) @(posedge clk);
      #2;
      check("sb_drained", 32'(exp_q.size()), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
